// File: rtl/mem_bus_responder.sv
// Memory-side responder: takes one read/write strobe at a time from the sequencer,
// runs a wait-stated SRAM access, and returns a one-cycle read-valid or write-done pulse.
module mem_bus_responder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int WAIT_STATES    = 2,
  parameter int WAIT_CNT_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rd_mem,
  input  logic                  i_wr_mem,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_wr_done,
  output logic                  o_busy,
  output logic                  o_conflict,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_re,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a strobe (i_rd_mem/i_wr_mem) is a request only while o_busy is low;
  // strobes seen while o_busy is high are dropped, never queued. Write wins a tie.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      op_wr_q;
  logic                      conflict_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;
  logic                      req;
  logic                      last_access;

  assign req         = i_rd_mem | i_wr_mem;
  assign last_access = (state_q == ACCESS) && (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      conflict_q <= 1'b0;
      if (state_q == IDLE && req) begin
        addr_q     <= i_addr;
        wdata_q    <= i_wr_data;
        op_wr_q    <= i_wr_mem;
        cnt_q      <= WAIT_LOAD;
        conflict_q <= i_rd_mem & i_wr_mem;
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - WAIT_CNT_WIDTH'(1);
      end
      // Read data is only guaranteed by the SRAM on the final access cycle.
      if (last_access && !op_wr_q) begin
        rd_data_q <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_mem_re   = 1'b0;
    o_mem_we   = 1'b0;
    o_rd_valid = 1'b0;
    o_wr_done  = 1'b0;
    case (state_q)
      ACCESS: begin
        o_mem_re = !op_wr_q;
        o_mem_we = op_wr_q && (cnt_q == '0);
      end
      DONE: begin
        o_rd_valid = !op_wr_q;
        o_wr_done  = op_wr_q;
      end
      default: ;
    endcase
  end

  assign o_busy      = (state_q != IDLE);
  assign o_conflict  = conflict_q;
  assign o_rd_data   = rd_data_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (WAIT_STATES=2 and 0), directed requests,
// timed event scoreboard plus direct checks of reset and hold behaviour.
module tb_mem_bus_responder;

  localparam int EV_RE   = 1;
  localparam int EV_CONF = 2;
  localparam int EV_WE   = 3;
  localparam int EV_RDV  = 4;
  localparam int EV_WRD  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  // event record: {kind[3], dut[1], cycle[16], addr[16], data[8]}
  logic [43:0] exp_q[$];

  logic        rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
  logic [15:0] addr_a = 0, addr_b = 0;
  logic [7:0]  wd_a = 0, wd_b = 0, mrd_a = 0, mrd_b = 0;

  logic [7:0]  rdata_a, rdata_b, mwd_a, mwd_b;
  logic [15:0] maddr_a, maddr_b;
  logic        rdv_a, rdv_b, wrd_a, wrd_b, busy_a, busy_b, conf_a, conf_b;
  logic        re_a, re_b, we_a, we_b;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(2), .WAIT_CNT_WIDTH(4)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_rd_mem(rd_a), .i_wr_mem(wr_a), .i_addr(addr_a),
    .i_wr_data(wd_a), .o_rd_data(rdata_a), .o_rd_valid(rdv_a), .o_wr_done(wrd_a),
    .o_busy(busy_a), .o_conflict(conf_a), .o_mem_addr(maddr_a), .o_mem_wdata(mwd_a),
    .o_mem_re(re_a), .o_mem_we(we_a), .i_mem_rdata(mrd_a), .o_dbg_state(st_a)
  );

  mem_bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0), .WAIT_CNT_WIDTH(4)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_rd_mem(rd_b), .i_wr_mem(wr_b), .i_addr(addr_b),
    .i_wr_data(wd_b), .o_rd_data(rdata_b), .o_rd_valid(rdv_b), .o_wr_done(wrd_b),
    .o_busy(busy_b), .o_conflict(conf_b), .o_mem_addr(maddr_b), .o_mem_wdata(mwd_b),
    .o_mem_re(re_b), .o_mem_we(we_b), .i_mem_rdata(mrd_b), .o_dbg_state(st_b)
  );

  function automatic logic [43:0] ev(input int kind, input int dut, input int c,
                                     input logic [15:0] a, input logic [7:0] d);
    logic [2:0]  k3;
    logic [15:0] c16;
    k3  = kind[2:0];
    c16 = c[15:0];
    return {k3, dut[0], c16, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sb_check(input logic [43:0] act);
    logic [43:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %h, expected nothing (kind=%0d)", act, act[43:41]);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL event: got %h, expected %h", act, e);
      end
    end
  endtask

  // Monitor: per cycle, per DUT, events in the order re, conf, we, rdv, wrd
  always @(negedge clk) begin
    if (mon_en) begin
      if (re_a)   sb_check(ev(EV_RE,   0, cyc, maddr_a, 8'h00));
      if (conf_a) sb_check(ev(EV_CONF, 0, cyc, 16'h0, 8'h00));
      if (we_a)   sb_check(ev(EV_WE,   0, cyc, maddr_a, mwd_a));
      if (rdv_a)  sb_check(ev(EV_RDV,  0, cyc, 16'h0, rdata_a));
      if (wrd_a)  sb_check(ev(EV_WRD,  0, cyc, 16'h0, 8'h00));
      if (re_b)   sb_check(ev(EV_RE,   1, cyc, maddr_b, 8'h00));
      if (conf_b) sb_check(ev(EV_CONF, 1, cyc, 16'h0, 8'h00));
      if (we_b)   sb_check(ev(EV_WE,   1, cyc, maddr_b, mwd_b));
      if (rdv_b)  sb_check(ev(EV_RDV,  1, cyc, 16'h0, rdata_b));
      if (wrd_b)  sb_check(ev(EV_WRD,  1, cyc, 16'h0, 8'h00));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int d, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [7:0] wd);
    if (d == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wd_a = wd;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = a; wd_b = wd;
    end
  endtask

  // Expected events for a request accepted in cycle k with ws wait states
  task automatic push_req(input int d, input int k, input int ws, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [7:0] wd, input logic [7:0] mdata);
    if (rd && wr) exp_q.push_back(ev(EV_CONF, d, k + 1, 16'h0, 8'h00));
    if (wr) begin
      exp_q.push_back(ev(EV_WE, d, k + 1 + ws, a, wd));
      exp_q.push_back(ev(EV_WRD, d, k + ws + 2, 16'h0, 8'h00));
    end else if (rd) begin
      for (int i = 0; i <= ws; i++) exp_q.push_back(ev(EV_RE, d, k + 1 + i, a, 8'h00));
      exp_q.push_back(ev(EV_RDV, d, k + ws + 2, 16'h0, mdata));
    end
  endtask

  initial begin
    int k;
    // reset state
    wait_cycles(3);
    @(negedge clk);
    chk("rst_busy",     busy_a, 0);
    chk("rst_state",    st_a, 0);
    chk("rst_rd_data",  rdata_a, 0);
    chk("rst_rd_valid", rdv_a, 0);
    chk("rst_wr_done",  wrd_a, 0);
    chk("rst_conflict", conf_a, 0);
    chk("rst_mem_re",   re_a, 0);
    chk("rst_mem_we",   we_a, 0);
    chk("rst_mem_addr", maddr_a, 0);
    chk("rst_mem_wdata", mwd_a, 0);
    chk("rst_busy_b",   busy_b, 0);
    chk("rst_rd_data_b", rdata_b, 0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: read C000, ws=2, busy profile
    k = cyc; mrd_a = 8'h5A;
    set_req(0, 1, 0, 16'hC000, 8'h00);
    push_req(0, k, 2, 1, 0, 16'hC000, 8'h00, 8'h5A);
    tick(); set_req(0, 0, 0, 16'h0, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("busy_profile", busy_a, (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("rd_data_after_read", rdata_a, 8'h5A);

    // 2: write FF80/A5, read data must hold
    k = cyc; mrd_a = 8'hEE;
    set_req(0, 0, 1, 16'hFF80, 8'hA5);
    push_req(0, k, 2, 0, 1, 16'hFF80, 8'hA5, 8'h00);
    tick(); set_req(0, 0, 0, 16'h0, 8'h00);
    wait_cycles(5);
    chk("rd_data_hold_on_write", rdata_a, 8'h5A);

    // 3: rd and wr together -> write only, conflict pulse
    k = cyc;
    set_req(0, 1, 1, 16'h1234, 8'h11);
    push_req(0, k, 2, 1, 1, 16'h1234, 8'h11, 8'h00);
    tick(); set_req(0, 0, 0, 16'h0, 8'h00);
    wait_cycles(5);

    // 4: ws=0, strobe held through DONE -> second access at k+4
    k = cyc; mrd_b = 8'h3C;
    set_req(1, 1, 0, 16'h0040, 8'h00);
    push_req(1, k, 0, 1, 0, 16'h0040, 8'h00, 8'h3C);
    push_req(1, k + 3, 0, 1, 0, 16'h0040, 8'h00, 8'hC3);
    tick(); tick(); tick();
    mrd_b = 8'hC3;
    tick(); set_req(1, 0, 0, 16'h0, 8'h00);
    wait_cycles(4);
    chk("rd_data_b_second", rdata_b, 8'hC3);

    // 5: reset mid-read aborts it
    k = cyc; mrd_a = 8'h99;
    set_req(0, 1, 0, 16'h2000, 8'h00);
    exp_q.push_back(ev(EV_RE, 0, k + 1, 16'h2000, 8'h00));
    exp_q.push_back(ev(EV_RE, 0, k + 2, 16'h2000, 8'h00));
    tick(); set_req(0, 0, 0, 16'h0, 8'h00);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_re",  re_a, 0);
    chk("abort_busy",    busy_a, 0);
    chk("abort_rd_data", rdata_a, 0);
    chk("abort_rd_data_b", rdata_b, 0);
    chk("abort_mem_addr", maddr_a, 0);
    tick();
    k = cyc; mrd_a = 8'h77;
    set_req(0, 1, 0, 16'h2001, 8'h00);
    push_req(0, k, 2, 1, 0, 16'h2001, 8'h00, 8'h77);
    tick(); set_req(0, 0, 0, 16'h0, 8'h00);
    wait_cycles(5);
    chk("rd_data_after_abort", rdata_a, 8'h77);

    // 6: strobes while busy are ignored
    k = cyc; mrd_a = 8'hE1;
    set_req(0, 1, 0, 16'h3000, 8'h00);
    push_req(0, k, 2, 1, 0, 16'h3000, 8'h00, 8'hE1);
    tick(); set_req(0, 1, 0, 16'h3111, 8'h00);
    tick(); set_req(0, 0, 1, 16'h3222, 8'h55);
    tick(); set_req(0, 0, 0, 16'h0, 8'h00);
    wait_cycles(5);
    chk("rd_data_busy_ignore", rdata_a, 8'hE1);
    chk("mem_addr_busy_ignore", maddr_a, 16'h3000);

    wait_cycles(3);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
